// File: rtl/pc_redirect_ctrl_if.sv
// Bundle of EX-stage control-flow inputs and redirect outputs for pc_redirect_ctrl.
// REDIR_CNT exists only when PC_REDIRECT_STATS_EN is defined.
interface pc_redirect_ctrl_if;
    logic        EN;
    logic        VALID_EX;
    logic [31:0] PC_EX;
    logic        IS_BR;
    logic        BR_TAKEN;
    logic        IS_J;
    logic        IS_JR;
    logic [15:0] IMM_EX;
    logic [25:0] JIDX_EX;
    logic [31:0] RS_VAL;
    logic [1:0]  PC_Sel;
    logic [31:0] PC_Branch;
    logic [31:0] PC_JAL;
    logic [31:0] JR;
    logic        flush;
    logic        squash;
    logic        busy;
`ifdef PC_REDIRECT_STATS_EN
    logic [31:0] REDIR_CNT;
`endif

    modport master (
        output EN, VALID_EX, PC_EX, IS_BR, BR_TAKEN, IS_J, IS_JR, IMM_EX, JIDX_EX, RS_VAL,
        input  PC_Sel, PC_Branch, PC_JAL, JR, flush, squash, busy
`ifdef PC_REDIRECT_STATS_EN
        , input REDIR_CNT
`endif
    );

    modport slave (
        input  EN, VALID_EX, PC_EX, IS_BR, BR_TAKEN, IS_J, IS_JR, IMM_EX, JIDX_EX, RS_VAL,
        output PC_Sel, PC_Branch, PC_JAL, JR, flush, squash, busy
`ifdef PC_REDIRECT_STATS_EN
        , output REDIR_CNT
`endif
    );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// PC redirect controller: latches branch/jump targets, pulses flush, then squashes wrong-path fetches.
// Optional redirect counter enabled by defining PC_REDIRECT_STATS_EN.
module pc_redirect_ctrl #(
    parameter int unsigned SQUASH_CYCLES = 3
) (
    input  logic              CLK,
    input  logic              RST_N,
    pc_redirect_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        REDIRECT,
        SQUASH
    } state_t;

    localparam logic [2:0] CNT_INIT = 3'(SQUASH_CYCLES);

    state_t      state_r, state_nx;
    logic [2:0]  cnt_r, cnt_nx;
    logic [1:0]  sel_r, sel_req;
    logic [31:0] br_tgt_r, jal_tgt_r, jr_tgt_r;
    logic [31:0] pc_plus4;
    logic [31:0] br_off;
    logic        req;
    logic        load;

    assign pc_plus4 = bus.PC_EX + 32'd4;
    assign br_off   = {{14{bus.IMM_EX[15]}}, bus.IMM_EX, 2'b00};
    assign req      = bus.VALID_EX & bus.EN &
                      (bus.IS_JR | bus.IS_J | (bus.IS_BR & bus.BR_TAKEN));

    // Register jump wins over direct jump, which wins over branch
    always_comb begin
        sel_req = 2'b01;
        if (bus.IS_JR)
            sel_req = 2'b00;
        else if (bus.IS_J)
            sel_req = 2'b11;
    end

    always_comb begin
        state_nx = state_r;
        cnt_nx   = cnt_r;
        load     = 1'b0;
        case (state_r)
            IDLE: begin
                if (req) begin
                    state_nx = REDIRECT;
                    load     = 1'b1;
                end
            end
            REDIRECT: begin
                if (bus.EN) begin
                    state_nx = SQUASH;
                    cnt_nx   = CNT_INIT;
                end
            end
            SQUASH: begin
                if (bus.EN) begin
                    if (cnt_r == 3'd1) begin
                        state_nx = IDLE;
                        cnt_nx   = 3'd0;
                    end else begin
                        cnt_nx = cnt_r - 3'd1;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= IDLE;
            cnt_r   <= 3'd0;
        end else begin
            state_r <= state_nx;
            cnt_r   <= cnt_nx;
        end
    end

    // Targets only change on an accepted request so they stay stable through stalls
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sel_r     <= 2'b10;
            br_tgt_r  <= 32'd0;
            jal_tgt_r <= 32'd0;
            jr_tgt_r  <= 32'd0;
        end else if (load) begin
            sel_r     <= sel_req;
            br_tgt_r  <= pc_plus4 + br_off;
            jal_tgt_r <= {pc_plus4[31:28], bus.JIDX_EX, 2'b00};
            jr_tgt_r  <= bus.RS_VAL;
        end
    end

    assign bus.PC_Sel    = (state_r == REDIRECT) ? sel_r : 2'b10;
    assign bus.flush     = (state_r == REDIRECT);
    assign bus.squash    = (state_r == SQUASH);
    assign bus.busy      = (state_r != IDLE);
    assign bus.PC_Branch = br_tgt_r;
    assign bus.PC_JAL    = jal_tgt_r;
    assign bus.JR        = jr_tgt_r;

`ifdef PC_REDIRECT_STATS_EN
    logic [31:0] redir_cnt_r;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            redir_cnt_r <= 32'd0;
        else if (load)
            redir_cnt_r <= redir_cnt_r + 32'd1;
    end

    assign bus.REDIR_CNT = redir_cnt_r;
`endif

endmodule
